// File: rtl/wb_slave_timer_if.sv
// wb_slave_timer_if: Wishbone classic bus signals between the bus controller and the timer slave
interface wb_slave_timer_if;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    modport master (
        output wbs_dat_i, wbs_adr_i, wbs_we_i, wbs_sel_i, wbs_cyc_i, wbs_stb_i,
        input  wbs_dat_o, wbs_ack_o
    );
    modport slave (
        input  wbs_dat_i, wbs_adr_i, wbs_we_i, wbs_sel_i, wbs_cyc_i, wbs_stb_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/wb_slave_timer.sv
// wb_slave_timer: Wishbone classic slave with a compare-match timer, irq and scratch register
module wb_slave_timer #(
    parameter logic [31:0] addr_base   = 32'h00001000,
    parameter int          wait_states = 0
) (
    input  logic               clk,
    input  logic               rst,
    wb_slave_timer_if.slave    bus,
    output logic               irq_o
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    localparam logic [3:0] wcnt_init = (wait_states > 0) ? 4'(wait_states - 1) : 4'd0;
    state_t      state, state_nx;
    logic [3:0]  wcnt;
    logic [2:0]  off_q;
    logic        we_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic [2:0]  ctrl;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] scratch;
    logic        status;
    logic [31:0] rdata;
    logic [31:0] rd_val;
    logic [2:0]  rd_off;
    logic        hit;
    logic        wr;
    logic        match;
    logic        unused;
    assign unused = ^bus.wbs_adr_i[1:0];
    assign hit    = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:5] == addr_base[31:5]);
    assign wr     = (state == ACK) & we_q;
    assign match  = ctrl[0] & (count == compare);
    // With zero wait states the snapshot is taken in the same edge that latches the address
    assign rd_off = (state == IDLE) ? bus.wbs_adr_i[4:2] : off_q;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
        for (int i = 0; i < 4; i++)
            merge[8*i +: 8] = sel[i] ? wd[8*i +: 8] : old[8*i +: 8];
    endfunction

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    // next-state: accept on hit, optionally wait, abort if cyc drops while waiting
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !hit ? IDLE : (wait_states == 0) ? ACK : WAIT;
            WAIT:    state_nx = !bus.wbs_cyc_i ? IDLE : (wcnt == 4'd0) ? ACK : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // outputs: ack for the single ACK cycle, read data gated to zero otherwise
    always_comb begin
        bus.wbs_ack_o = (state == ACK);
        bus.wbs_dat_o = (state == ACK) ? rdata : 32'd0;
    end

    // request capture and wait-state counter
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            off_q <= '0;
            we_q  <= 1'b0;
            dat_q <= '0;
            sel_q <= '0;
            wcnt  <= '0;
        end else begin
            if (state == IDLE && hit) begin
                off_q <= bus.wbs_adr_i[4:2];
                we_q  <= bus.wbs_we_i;
                dat_q <= bus.wbs_dat_i;
                sel_q <= bus.wbs_sel_i;
            end
            wcnt <= (state == IDLE) ? wcnt_init : wcnt - 4'd1;
        end

    // register read mux; offsets 5..7 read as zero
    always_comb
        rd_val = (rd_off == 3'd0) ? {29'd0, ctrl} :
                 (rd_off == 3'd1) ? count :
                 (rd_off == 3'd2) ? compare :
                 (rd_off == 3'd3) ? {31'd0, status} :
                 (rd_off == 3'd4) ? scratch : 32'd0;

    // read snapshot taken on the edge entering ACK
    always_ff @(posedge clk or posedge rst)
        if (rst) rdata <= '0;
        else if (state_nx == ACK && state != ACK) rdata <= rd_val;

    // timer and register writes; a bus write to COUNT overrides increment/reload
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ctrl    <= '0;
            count   <= '0;
            compare <= 32'hFFFF_FFFF;
            scratch <= '0;
        end else begin
            if (wr && off_q == 3'd1)   count <= merge(count, dat_q, sel_q);
            else if (ctrl[0])          count <= (match && ctrl[1]) ? 32'd0 : count + 32'd1;
            if (wr && off_q == 3'd0 && sel_q[0]) ctrl <= dat_q[2:0];
            if (wr && off_q == 3'd2)   compare <= merge(compare, dat_q, sel_q);
            if (wr && off_q == 3'd4)   scratch <= merge(scratch, dat_q, sel_q);
        end

    // match flag (set beats write-1-to-clear) and registered interrupt
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            status <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (match) status <= 1'b1;
            else if (wr && off_q == 3'd3 && sel_q[0] && dat_q[0]) status <= 1'b0;
            irq_o <= status & ctrl[2];
        end
endmodule
